modclk_trigger_decoder: RTL and testbench

- Receive-end decoder for the combiner's trigger-modulated clock on the mPMT side of the RJ45 cable.
- Oversamples the incoming carrier with a local clock and measures each carrier period and its high time.
- Recovers the trigger bit per period: 25% duty = 0, 75% duty = 1, or a missing carrier pulse = 1 in missing-clock mode.
- Reports carrier lock and a saturating error count; the results feed the mPMT trigger/timestamp logic.

---
 rtl/combiner_pkg.sv | 45 ++++
 rtl/modclk_trigger_decoder_if.sv | 25 ++
 rtl/modclk_sync_edge.sv | 33 +++
 rtl/modclk_trigger_decoder.sv | 181 ++++++++++++++++++
 tb/tb_modclk_trigger_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/combiner_pkg.sv
// Types and constants shared by the trigger combiner and the mPMT-side decoder,
// plus the per-period classifier used by the decoder.
package combiner_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic MODE_DUTY    = 1'b1;
  localparam logic MODE_MISSING = 1'b0;

  localparam int N_SAMP_DEF = 16;
  localparam int TOL_DEF    = 2;

  typedef struct packed {
    logic good;
    logic bval;
  } decision_t;

  // p = samples in the period, h = high samples in it
  function automatic decision_t classify(input int p, input int h, input logic mode,
                                         input int n_samp, input int tol);
    decision_t d;
    d.good = 1'b0;
    d.bval = 1'b0;
    if (mode == MODE_DUTY) begin
      if (p >= n_samp - tol && p <= n_samp + tol && 2 * h != p) begin
        d.good = 1'b1;
        d.bval = (2 * h > p);
      end
    end else begin
      if (p >= n_samp - tol && p <= n_samp + tol) begin
        d.good = 1'b1;
        d.bval = 1'b0;
      end else if (p >= 2 * n_samp - tol && p <= 2 * n_samp + tol) begin
        d.good = 1'b1;
        d.bval = 1'b1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/modclk_trigger_decoder_if.sv
// Signal bundle between the cable receiver / trigger logic and the decoder.
// No handshake: mod_in is a free-running carrier, results are one-cycle strobes.
interface modclk_trigger_decoder_if;
  import combiner_pkg::*;

  logic       mod_in;
  logic       trig_sel;
  logic       trig_out;
  logic       trig_valid;
  logic       trig_pulse;
  logic       locked;
  logic [7:0] err_count;
  state_t     dbg_state;

  modport master (
    output mod_in, trig_sel,
    input  trig_out, trig_valid, trig_pulse, locked, err_count, dbg_state
  );

  modport slave (
    input  mod_in, trig_sel,
    output trig_out, trig_valid, trig_pulse, locked, err_count, dbg_state
  );

endinterface

// File: rtl/modclk_sync_edge.sv
// Two-flop synchroniser for the asynchronous carrier plus a registered rising-edge
// detector; o_s is delayed one flop so that o_rise and o_s=1 coincide on the edge sample.
module modclk_sync_edge (
  input  logic osc_clk0,
  input  logic reset_n,
  input  logic i_d,
  output logic o_s,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;

  always_ff @(posedge osc_clk0) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign o_s    = r_s3;
  assign o_rise = r_rise;

endmodule

// File: rtl/modclk_trigger_decoder.sv
// Receive-side decoder for the trigger-modulated carrier: measures each carrier period,
// recovers one trigger bit per period and tracks lock and a saturating error count.
module modclk_trigger_decoder
  import combiner_pkg::*;
#(
  parameter int N_SAMP       = N_SAMP_DEF,
  parameter int TOL          = TOL_DEF,
  parameter int CNT_W        = 7,
  parameter int LOCK_PERIODS = 8
) (
  input  logic                     osc_clk0,
  input  logic                     reset_n,
  modclk_trigger_decoder_if.slave  dec_if
);

  localparam int               LC_W    = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             w_s;
  logic             w_rise;
  logic [CNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             w_psat;
  decision_t        w_dec;
  logic             w_good;

  logic             r_sel;
  logic             w_mode_chg;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LC_W-1:0]  r_lock_cnt;
  logic [LC_W-1:0]  w_lock_nxt;
  logic             r_trig_out;
  logic             w_trig_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             w_err_inc;
  logic [7:0]       r_err;

  modclk_sync_edge u_sync_edge (
    .osc_clk0 (osc_clk0),
    .reset_n  (reset_n),
    .i_d      (dec_if.mod_in),
    .o_s      (w_s),
    .o_rise   (w_rise)
  );

  // The edge sample opens the next period, so it is counted as its first sample.
  always_ff @(posedge osc_clk0) begin
    if (!reset_n) begin
      r_pcnt <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_pcnt <= CNT_W'(1);
      r_hcnt <= CNT_W'(1);
    end else begin
      if (r_pcnt != CNT_MAX)
        r_pcnt <= r_pcnt + CNT_W'(1);
      if (w_s && r_hcnt != CNT_MAX)
        r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge osc_clk0) begin
    if (!reset_n)
      r_sel <= dec_if.trig_sel;
    else
      r_sel <= dec_if.trig_sel;
  end

  assign w_mode_chg = (dec_if.trig_sel != r_sel);
  assign w_psat     = (r_pcnt == CNT_MAX);
  assign w_dec      = classify(int'(r_pcnt), int'(r_hcnt), r_sel, N_SAMP, TOL);
  assign w_good     = w_dec.good & ~w_psat;

  always_comb begin
    w_state_nxt  = r_state;
    w_lock_nxt   = r_lock_cnt;
    w_locked_nxt = r_locked;
    w_trig_nxt   = r_trig_out;
    w_valid_nxt  = 1'b0;
    w_pulse_nxt  = 1'b0;
    w_err_inc    = 1'b0;
    // HUNT is already waiting for an edge, so a mode change there changes nothing.
    if (r_state != HUNT && w_mode_chg) begin
      w_state_nxt  = ACQ;
      w_lock_nxt   = '0;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        HUNT: begin
          w_lock_nxt = '0;
          if (w_rise)
            w_state_nxt = ACQ;
        end
        ACQ: begin
          if (w_rise) begin
            if (w_good) begin
              if (r_lock_cnt == LC_W'(LOCK_PERIODS - 1)) begin
                w_state_nxt  = LOCK;
                w_locked_nxt = 1'b1;
                w_lock_nxt   = '0;
              end else begin
                w_lock_nxt = r_lock_cnt + LC_W'(1);
              end
            end else begin
              w_err_inc  = 1'b1;
              w_lock_nxt = '0;
            end
          end else if (w_psat) begin
            w_state_nxt  = HUNT;
            w_err_inc    = 1'b1;
            w_lock_nxt   = '0;
            w_locked_nxt = 1'b0;
            w_trig_nxt   = 1'b0;
          end
        end
        LOCK: begin
          if (w_rise) begin
            if (w_good) begin
              w_trig_nxt  = w_dec.bval;
              w_valid_nxt = 1'b1;
              w_pulse_nxt = w_dec.bval & ~r_trig_out;
            end else begin
              w_err_inc    = 1'b1;
              w_locked_nxt = 1'b0;
              w_lock_nxt   = '0;
              w_state_nxt  = ACQ;
            end
          end else if (w_psat) begin
            w_state_nxt  = HUNT;
            w_err_inc    = 1'b1;
            w_lock_nxt   = '0;
            w_locked_nxt = 1'b0;
            w_trig_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt  = HUNT;
          w_lock_nxt   = '0;
          w_locked_nxt = 1'b0;
          w_trig_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge osc_clk0) begin
    if (!reset_n) begin
      r_state    <= HUNT;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_trig_out <= 1'b0;
      r_valid    <= 1'b0;
      r_pulse    <= 1'b0;
      r_err      <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_locked   <= w_locked_nxt;
      r_trig_out <= w_trig_nxt;
      r_valid    <= w_valid_nxt;
      r_pulse    <= w_pulse_nxt;
      if (w_err_inc && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
    end
  end

  assign dec_if.trig_out   = r_trig_out;
  assign dec_if.trig_valid = r_valid;
  assign dec_if.trig_pulse = r_pulse;
  assign dec_if.locked     = r_locked;
  assign dec_if.err_count  = r_err;
  assign dec_if.dbg_state  = r_state;

endmodule

// File: tb/tb_modclk_trigger_decoder.sv
// Directed bench for modclk_trigger_decoder: carrier periods are driven sample by sample
// and the outputs are checked against hand-computed values.
module tb_modclk_trigger_decoder;
  import combiner_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   mon_valid = 0;
  int   mon_pulse = 0;
  int   mon_vidx  = -1;

  modclk_trigger_decoder_if dut_if ();

  modclk_trigger_decoder #(
    .N_SAMP       (16),
    .TOL          (2),
    .CNT_W        (7),
    .LOCK_PERIODS (8)
  ) dut (
    .osc_clk0 (clk),
    .reset_n  (reset_n),
    .dec_if   (dut_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_valid = 0;
    mon_pulse = 0;
    mon_vidx  = -1;
  endtask

  // One carrier period: p samples, the first h of them high. Outputs are sampled on the
  // falling edge just before the next sample is driven.
  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (dut_if.trig_valid === 1'b1) begin
        mon_valid++;
        mon_vidx = i;
      end
      if (dut_if.trig_pulse === 1'b1)
        mon_pulse++;
      dut_if.mod_in = (i < h);
    end
  endtask

  task automatic drive_n(input int n, input int p, input int h);
    for (int k = 0; k < n; k++)
      drive_period(p, h);
  endtask

  initial begin
    reset_n         = 1'b0;
    dut_if.mod_in   = 1'b0;
    dut_if.trig_sel = MODE_DUTY;
    repeat (3) @(negedge clk);
    chk("rst_trig_out", 32'(dut_if.trig_out), 0);
    chk("rst_valid", 32'(dut_if.trig_valid), 0);
    chk("rst_pulse", 32'(dut_if.trig_pulse), 0);
    chk("rst_locked", 32'(dut_if.locked), 0);
    chk("rst_err", 32'(dut_if.err_count), 0);
    chk("rst_state", 32'(dut_if.dbg_state), 32'(HUNT));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 25% duty carrier: first edge only leaves HUNT, lock at the 8th decision
    clear_mon();
    drive_n(8, 16, 4);
    chk("t1_not_locked_7", 32'(dut_if.locked), 0);
    drive_n(1, 16, 4);
    chk("t1_locked_8", 32'(dut_if.locked), 1);
    chk("t1_no_valid_acq", 32'(mon_valid), 0);
    drive_n(11, 16, 4);
    chk("t1_valid_cnt", 32'(mon_valid), 11);
    chk("t1_latency_idx", 32'(mon_vidx), 4);
    chk("t1_trig_out", 32'(dut_if.trig_out), 0);
    chk("t1_pulse_cnt", 32'(mon_pulse), 0);
    chk("t1_err", 32'(dut_if.err_count), 0);

    // one 75% period, then 25% with tolerance-edge periods P=18 and P=14
    clear_mon();
    drive_period(16, 12);
    drive_period(16, 4);
    chk("t2_trig_one", 32'(dut_if.trig_out), 1);
    chk("t2_pulse_once", 32'(mon_pulse), 1);
    drive_period(16, 4);
    drive_period(18, 4);
    drive_period(14, 3);
    drive_period(16, 4);
    chk("t2_trig_zero", 32'(dut_if.trig_out), 0);
    chk("t2_pulse_still1", 32'(mon_pulse), 1);
    chk("t2_valid_cnt", 32'(mon_valid), 6);
    chk("t2_locked", 32'(dut_if.locked), 1);
    chk("t2_err", 32'(dut_if.err_count), 0);

    // one P=20 period drops lock; 8 good periods relock
    clear_mon();
    drive_period(20, 5);
    drive_period(16, 4);
    chk("t3_err", 32'(dut_if.err_count), 1);
    chk("t3_unlocked", 32'(dut_if.locked), 0);
    chk("t3_valid_before", 32'(mon_valid), 1);
    chk("t3_state_acq", 32'(dut_if.dbg_state), 32'(ACQ));
    clear_mon();
    drive_n(7, 16, 4);
    chk("t3_not_yet", 32'(dut_if.locked), 0);
    drive_n(1, 16, 4);
    chk("t3_relock", 32'(dut_if.locked), 1);
    chk("t3_no_valid_acq", 32'(mon_valid), 0);
    drive_n(1, 16, 4);
    chk("t3_valid_after", 32'(mon_valid), 1);

    // carrier stuck high after a 75% period
    clear_mon();
    drive_period(16, 12);
    drive_period(200, 200);
    chk("t4_err", 32'(dut_if.err_count), 2);
    chk("t4_trig_forced0", 32'(dut_if.trig_out), 0);
    chk("t4_unlocked", 32'(dut_if.locked), 0);
    chk("t4_state_hunt", 32'(dut_if.dbg_state), 32'(HUNT));
    chk("t4_valid_cnt", 32'(mon_valid), 2);
    chk("t4_pulse_cnt", 32'(mon_pulse), 1);
    drive_period(4, 0);
    drive_n(8, 16, 4);
    chk("t4_not_yet", 32'(dut_if.locked), 0);
    drive_n(1, 16, 4);
    chk("t4_relock", 32'(dut_if.locked), 1);
    chk("t4_err_kept", 32'(dut_if.err_count), 2);

    // missing-clock mode: mode change forces ACQ, then a P=32 period decodes as 1
    dut_if.trig_sel = MODE_MISSING;
    drive_period(16, 4);
    chk("t5_mode_unlock", 32'(dut_if.locked), 0);
    chk("t5_mode_state", 32'(dut_if.dbg_state), 32'(ACQ));
    chk("t5_mode_no_err", 32'(dut_if.err_count), 2);
    drive_n(7, 16, 4);
    chk("t5_relock", 32'(dut_if.locked), 1);
    clear_mon();
    drive_period(32, 4);
    drive_period(16, 4);
    chk("t5_valid_cnt", 32'(mon_valid), 2);
    chk("t5_pulse_cnt", 32'(mon_pulse), 1);
    chk("t5_trig_one", 32'(dut_if.trig_out), 1);
    chk("t5_err", 32'(dut_if.err_count), 2);

    // reset in the middle of a period
    drive_period(6, 4);
    reset_n         = 1'b0;
    dut_if.mod_in   = 1'b0;
    dut_if.trig_sel = MODE_DUTY;
    @(negedge clk);
    chk("t6_trig_out", 32'(dut_if.trig_out), 0);
    chk("t6_locked", 32'(dut_if.locked), 0);
    chk("t6_err", 32'(dut_if.err_count), 0);
    chk("t6_valid", 32'(dut_if.trig_valid), 0);
    chk("t6_pulse", 32'(dut_if.trig_pulse), 0);
    chk("t6_state", 32'(dut_if.dbg_state), 32'(HUNT));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 50% duty (2H==P) is bad, then P=24 periods saturate err_count
    clear_mon();
    drive_n(3, 16, 8);
    chk("t7_half_duty_err", 32'(dut_if.err_count), 2);
    drive_n(50, 24, 6);
    chk("t7_err_mid", 32'(dut_if.err_count), 52);
    drive_n(250, 24, 6);
    chk("t7_err_sat", 32'(dut_if.err_count), 255);
    drive_n(5, 24, 6);
    chk("t7_err_hold", 32'(dut_if.err_count), 255);
    chk("t7_locked", 32'(dut_if.locked), 0);
    chk("t7_valid_cnt", 32'(mon_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
